// File: rtl/ps2_device_tx.sv
// PS/2 device-side transmitter: scan-code FIFO, 11-bit framing, inhibit retry.
// Define PS2_TX_BREAK_EN to send release entries as an F0-prefixed frame pair.
module ps2_device_tx #(
  parameter int CLK_DIV    = 2500,
  parameter int FIFO_AW    = 3,
  parameter int GAP_CYCLES = 5000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [7:0]       wr_code,
  input  logic             wr_release,
  output logic             full,
  output logic [FIFO_AW:0] count,
  output logic             busy,
  output logic             overflow,
  output logic             frame_done,
  output logic             abort,
  input  logic             ps2_clk_i,
  output logic             ps2_clk_o,
  output logic             ps2_data_o
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int MAXC  = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CW    = $clog2(MAXC) + 1;
`ifdef PS2_TX_BREAK_EN
  localparam int EW = 9;
`else
  localparam int EW = 8;
`endif

  typedef enum logic [2:0] {IDLE, SETUP, LOW, GAP, INH} state_t;

  state_t             state, state_n;
  logic [3:0]         idx, idx_n;
  logic [CW-1:0]      cnt;
  logic [EW-1:0]      mem [DEPTH];
  logic [EW-1:0]      entry, head;
  logic [FIFO_AW-1:0] wptr, rptr;
  logic [FIFO_AW:0]   fill;
  logic [1:0]         sync;
  logic [7:0]         code;
  logic [10:0]        frame;
  logic               push, pop, fd_p, pop_p, split;
  logic               cnt_last, abort_now, done_now;
  logic               clk_n, data_n;

`ifdef PS2_TX_BREAK_EN
  logic second;
  assign entry = {wr_release, wr_code};
  assign split = head[8] & ~second;
  assign code  = split ? 8'hF0 : head[7:0];
`else
  logic unused_release;
  assign unused_release = wr_release;
  assign entry = wr_code;
  assign split = 1'b0;
  assign code  = head;
`endif

  assign head  = mem[rptr];
  assign frame = {1'b1, ~^code, code, 1'b0};
  assign full  = (fill == (FIFO_AW + 1)'(DEPTH));
  assign count = fill;
  assign busy  = (state != IDLE);
  assign pop   = pop_p;
  // A full FIFO still takes a write in the cycle the head is popped.
  assign push  = wr_en & (~full | pop);

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      fill     <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en & ~push;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: ;
      endcase
    end
  end

  assign cnt_last  = (state == GAP) ? (cnt == CW'(GAP_CYCLES - 1))
                                    : (cnt == CW'(CLK_DIV - 1));
  assign abort_now = (state == SETUP) && (idx < 4'd10) && !sync[1];
  assign done_now  = (state == LOW) && (idx == 4'd10) && cnt_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
      sync  <= 2'b11;
      fd_p  <= 1'b0;
      pop_p <= 1'b0;
`ifdef PS2_TX_BREAK_EN
      second <= 1'b0;
`endif
    end else begin
      sync  <= {sync[0], ps2_clk_i};
      state <= state_n;
      idx   <= idx_n;
      cnt   <= (state_n != state) ? '0 : cnt + CW'(1);
      fd_p  <= done_now;
      pop_p <= done_now & ~split;
`ifdef PS2_TX_BREAK_EN
      if (done_now)       second <= split;
      else if (abort_now) second <= 1'b0;
`endif
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    unique case (state)
      IDLE:
        if (fill != '0) begin
          state_n = SETUP;
          idx_n   = '0;
        end
      SETUP:
        if (abort_now)     state_n = INH;
        else if (cnt_last) state_n = LOW;
      LOW:
        if (cnt_last) begin
          if (idx == 4'd10) begin
            state_n = GAP;
          end else begin
            state_n = SETUP;
            idx_n   = idx + 4'd1;
          end
        end
      GAP:
        if (cnt_last) state_n = IDLE;
      INH:
        if (sync[1]) state_n = GAP;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    clk_n  = (state != LOW);
    data_n = 1'b1;
    if (state == SETUP || state == LOW) data_n = frame[idx];
  end

  // Line drives and pulses are registered so the pins never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      ps2_clk_o  <= 1'b1;
      ps2_data_o <= 1'b1;
      frame_done <= 1'b0;
      abort      <= 1'b0;
    end else begin
      ps2_clk_o  <= clk_n;
      ps2_data_o <= data_n;
      frame_done <= fd_p;
      abort      <= abort_now;
    end
  end

endmodule
